i2c_slave_ctrl: RTL and testbench

// - I2C target (slave) controller: the responder opposite our I2C master control FSM on the same bus.
// - Oversamples SCL/SDA on clk, detects START/STOP, matches 7-bit address, ACKs, receives write bytes, supplies read bytes.
// - Sits between open-drain pad logic (SDA pull-down enable) and a byte-wide user interface.

---
 rtl/i2c_pkg.sv | 9 +
 rtl/i2c_slv_sync_filt.sv | 35 +++
 rtl/i2c_slave_ctrl.sv | 174 +++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and ACK/NACK bus levels.
package i2c_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK, ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
endpackage

// File: rtl/i2c_slv_sync_filt.sv
// Two-flop synchronizer + FILT_LEN-sample glitch filter with rise/fall strobes.
// Filtered level follows the pad 2+FILT_LEN clocks later; strobes align with it.
module i2c_slv_sync_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  // sh[0] is the metastability stage; sh[FILT_LEN:1] is the filter window.
  logic [FILT_LEN:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '1;
      lvl  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sh   <= {sh[FILT_LEN-1:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if ((&sh[FILT_LEN:1]) && !lvl) begin
        lvl  <= 1'b1;
        rise <= 1'b1;
      end else if (!(|sh[FILT_LEN:1]) && lvl) begin
        lvl  <= 1'b0;
        fall <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: START/STOP detect, address match, byte RX/TX with ACK.
// Define I2C_SLV_GEN_CALL_EN to also accept the general-call write address 8'h00.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = 7'h42,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       stop_det
);
`ifdef I2C_SLV_GEN_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_slv_sync_filt #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(clk), .rst_n(rst_n), .din(scl_i), .lvl(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_slv_sync_filt #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(clk), .rst_n(rst_n), .din(sda_i), .lvl(sda), .rise(sda_rise), .fall(sda_fall));

  i2c_state_e state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       rw;
  logic       ack_half;   // ACK slot: driving/ACK sampled, waiting for the closing fall
  logic       tx_load;    // tx_data is sampled the cycle after tx_req

  logic       start_c, stop_c, addr_hit;
  logic [7:0] byte_in;

  assign start_c  = sda_fall && scl;
  assign stop_c   = sda_rise && scl;
  assign byte_in  = {shift[6:0], sda};
  assign addr_hit = (byte_in[7:1] == SLV_ADDR) || (GC_EN && byte_in == 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rw       <= 1'b0;
      ack_half <= 1'b0;
      tx_load  <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      stop_det <= 1'b0;
      tx_load  <= tx_req;
      if (stop_c) begin
        state    <= ST_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
        ack_half <= 1'b0;
      end else if (start_c) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        ack_half <= 1'b0;
      end else begin
        if (tx_load) begin
          // Re-entry from TX_ACK already passed its driving fall, so drive bit 7 now.
          if (state == ST_TX) begin
            shift  <= {tx_data[6:0], 1'b0};
            sda_oe <= ~tx_data[7];
          end else begin
            shift  <= tx_data;
          end
        end
        unique case (state)
          ST_IDLE, ST_WAIT_STOP: sda_oe <= 1'b0;
          ST_ADDR: if (scl_rise) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_hit && !(byte_in == 8'h00 && sda)) begin
                state    <= ST_ADDR_ACK;
                busy     <= 1'b1;
                rw       <= sda;
                ack_half <= 1'b0;
              end else begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK, ST_RX_ACK: if (scl_fall) begin
            if (!ack_half) begin
              sda_oe   <= 1'b1;
              ack_half <= 1'b1;
              if (state == ST_ADDR_ACK && rw) tx_req <= 1'b1;
            end else begin
              ack_half <= 1'b0;
              bit_cnt  <= '0;
              if (state == ST_ADDR_ACK && rw) begin
                state  <= ST_TX;
                sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
              end else begin
                state  <= ST_RX;
                sda_oe <= 1'b0;
              end
            end
          end
          ST_RX: if (scl_rise) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data <= byte_in;
              if (rx_ready) begin
                rx_valid <= 1'b1;
                state    <= ST_RX_ACK;
                ack_half <= 1'b0;
              end else begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end
            end
          end
          ST_TX: begin
            if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe   <= 1'b0;
                state    <= ST_TX_ACK;
                ack_half <= 1'b0;
              end else begin
                sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_ACK) begin
                ack_half <= 1'b1;
              end else begin
                state <= ST_WAIT_STOP;
                busy  <= 1'b0;
              end
            end else if (scl_fall && ack_half) begin
              ack_half <= 1'b0;
              tx_req   <= 1'b1;
              bit_cnt  <= '0;
              state    <= ST_TX;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench: bus-master model at SCL = clk/16 driving an open-drain SDA line.
module tb_i2c_slave_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_i, sda_i, sda_oe;
  logic [7:0] rx_data, tx_data = 8'hFF;
  logic       rx_valid, rx_ready = 1'b1, tx_req, busy, stop_det;

  int n_chk = 0, n_pass = 0;
  int rx_cnt = 0, txr_cnt = 0, stop_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [7:0] rx_log [0:31];
  logic [7:0] tx_list [0:7];
  int tx_idx = 0, hold = 0;

  always #5 clk = ~clk;
  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  i2c_slave_ctrl #(.SLV_ADDR(7'h42), .FILT_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_req(tx_req),
    .tx_data(tx_data), .busy(busy), .stop_det(stop_det));

  // Event counters; tx_data is presented only around each tx_req, garbage otherwise.
  always @(negedge clk) begin
    if (rx_valid) begin rx_log[rx_cnt[4:0]] = rx_data; rx_cnt++; end
    if (stop_det) stop_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (tx_req) begin
      txr_cnt++;
      tx_data = tx_list[tx_idx[2:0]];
      tx_idx++;
      hold = 2;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) tx_data = 8'hFF;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic r);
    clks(4); sda_m = b;
    clks(4); scl_m = 1'b1;
    clks(4); r = sda_i;
    clks(4); scl_m = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin bus_bit(1'b1, r); d[i] = r; end
    bus_bit(mack, r);
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      clks(4); sda_m = 1'b1;
      clks(4); scl_m = 1'b1;
      clks(4);
    end
    sda_m = 1'b0; clks(8);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    clks(4); sda_m = 1'b0;
    clks(4); scl_m = 1'b1;
    clks(4); sda_m = 1'b1;
    clks(16);
  endtask

  initial begin
    logic a;
    logic [7:0] d;
    int rx0, tx0, st0, oe0, bz0;
    tx_list[0] = 8'h5A; tx_list[1] = 8'hC3; tx_list[2] = 8'h96; tx_list[3] = 8'h00;
    for (int i = 4; i < 8; i++) tx_list[i] = 8'hEE;

    clks(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stop_det", stop_det, 0);
    rst_n = 1'b1;
    clks(20);

    // Write A5, 3C
    rx0 = rx_cnt; st0 = stop_cnt;
    bus_start();
    wr_byte(8'h84, a); chk("wr_addr_ack", a, 0);
    chk("wr_busy", busy, 1);
    wr_byte(8'hA5, a); chk("wr_b0_ack", a, 0);
    wr_byte(8'h3C, a); chk("wr_b1_ack", a, 0);
    bus_stop();
    chk("wr_rx_cnt", rx_cnt - rx0, 2);
    chk("wr_rx0", rx_log[rx0], 8'hA5);
    chk("wr_rx1", rx_log[rx0+1], 8'h3C);
    chk("wr_stop_cnt", stop_cnt - st0, 1);
    chk("wr_busy_after", busy, 0);

    // Read 5A (master ACK), C3 (master NACK)
    tx0 = txr_cnt; st0 = stop_cnt;
    bus_start();
    wr_byte(8'h85, a); chk("rd_addr_ack", a, 0);
    rd_byte(1'b0, d); chk("rd_b0", d, 8'h5A);
    rd_byte(1'b1, d); chk("rd_b1", d, 8'hC3);
    clks(8);
    chk("rd_tx_req_cnt", txr_cnt - tx0, 2);
    chk("rd_wait_stop_busy", busy, 0);
    chk("rd_no_drive", sda_oe, 0);
    bus_stop();
    chk("rd_stop_cnt", stop_cnt - st0, 1);

    // Address mismatch
    rx0 = rx_cnt; oe0 = oe_cnt; bz0 = busy_cnt;
    bus_start();
    wr_byte(8'h86, a); chk("mm_addr_nack", a, 1);
    wr_byte(8'h11, a); chk("mm_data_nack", a, 1);
    bus_stop();
    chk("mm_oe_cycles", oe_cnt - oe0, 0);
    chk("mm_rx_cnt", rx_cnt - rx0, 0);
    chk("mm_busy_cycles", busy_cnt - bz0, 0);

    // Repeated START: write 01 then read 96
    rx0 = rx_cnt; tx0 = txr_cnt; st0 = stop_cnt;
    bus_start();
    wr_byte(8'h84, a);
    wr_byte(8'h01, a); chk("rs_wr_ack", a, 0);
    bus_start();
    wr_byte(8'h85, a); chk("rs_rd_addr_ack", a, 0);
    rd_byte(1'b1, d); chk("rs_rd_data", d, 8'h96);
    chk("rs_rx_cnt", rx_cnt - rx0, 1);
    chk("rs_rx_byte", rx_log[rx0], 8'h01);
    chk("rs_tx_req_cnt", txr_cnt - tx0, 1);
    chk("rs_no_stop_yet", stop_cnt - st0, 0);
    bus_stop();
    chk("rs_stop_cnt", stop_cnt - st0, 1);

    // Back-pressure: NACK on 77
    rx0 = rx_cnt;
    bus_start();
    wr_byte(8'h84, a);
    rx_ready = 1'b0;
    wr_byte(8'h77, a); chk("bp_nack", a, 1);
    chk("bp_rx_cnt", rx_cnt - rx0, 0);
    chk("bp_busy", busy, 0);
    bus_stop();
    rx_ready = 1'b1;

    // General call
    rx0 = rx_cnt;
    bus_start();
`ifdef I2C_SLV_GEN_CALL_EN
    wr_byte(8'h00, a); chk("gc_addr_ack", a, 0);
    wr_byte(8'h5E, a); chk("gc_data_ack", a, 0);
    chk("gc_rx_cnt", rx_cnt - rx0, 1);
    chk("gc_rx_byte", rx_log[rx0], 8'h5E);
`else
    wr_byte(8'h00, a); chk("gc_addr_nack", a, 1);
    wr_byte(8'h5E, a); chk("gc_data_nack", a, 1);
    chk("gc_rx_cnt", rx_cnt - rx0, 0);
`endif
    bus_stop();

    // Reset mid-TX while driving a 0 bit
    bus_start();
    wr_byte(8'h85, a);
    bus_bit(1'b1, a); chk("rt_bit0", a, 0);
    clks(2);
    chk("rt_driving", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rt_oe_released", sda_oe, 0);
    chk("rt_busy", busy, 0);
    clks(3);
    rst_n = 1'b1;
    bus_stop();
    chk("rt_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
